// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO and STATUS readback.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1 frames).
module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0040,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shift, head;
    logic ovf, empty, full, data_wr, stat_clr, baud_done, pop, push;
    logic unused_bits;

    assign unused_bits = ^iobus_out[31:8];
    assign empty     = count == '0;
    assign full      = count == CW'(FIFO_DEPTH);
    assign data_wr   = iobus_wr && iobus_addr == BASE_ADDR;
    assign stat_clr  = iobus_wr && iobus_addr == STAT_ADDR && iobus_out[3];
    assign baud_done = baud == '0;
    assign head      = mem[rd_ptr];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign pop       = !empty && (state == IDLE || (state == STOP && baud_done));
    assign push      = data_wr && (!full || pop);
    assign rd_hit    = iobus_addr == STAT_ADDR;
    assign rd_data   = rd_hit ? {19'd0, 5'(count), 4'd0, ovf, full, empty, state != IDLE} : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= iobus_out[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (data_wr && full && !pop) ovf <= 1'b1;
            else if (stat_clr) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            baud    <= RELOAD;
            bit_idx <= '0;
            shift   <= head;
`ifdef UART_TX_PARITY_EN
            par     <= ^head;
`endif
        end else begin
            case (state)
                IDLE: tx <= 1'b1;
                START: begin
                    baud <= baud_done ? RELOAD : baud - 1'b1;
                    if (baud_done) begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                end
                DATA: begin
                    baud <= baud_done ? RELOAD : baud - 1'b1;
                    if (baud_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= par;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else if (baud_done) begin
                        bit_idx <= bit_idx + 1'b1;
                        shift   <= shift >> 1;
                        tx      <= shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    baud <= baud_done ? RELOAD : baud - 1'b1;
                    if (baud_done) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    baud <= baud_done ? RELOAD : baud - 1'b1;
                    if (baud_done) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iobus_uart_tx.sv
// tb_iobus_uart_tx: randomized and directed checks of iobus_uart_tx against a frame-timing model.
module tb_iobus_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] BASE = 32'h1100_0040;
    localparam logic [31:0] STAT = 32'h1100_0044;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0, rst_n = 1'b0, iobus_wr = 1'b0, tx, rd_hit;
    logic [31:0] iobus_addr = STAT, iobus_out = '0, rd_data;
    int tests = 0, fails = 0, t = 0, last_end = 0;
    int starts[$];
    logic [7:0] bytes[$];
    logic ovf = 1'b0;

    iobus_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .iobus_addr(iobus_addr), .iobus_out(iobus_out),
        .iobus_wr(iobus_wr), .rd_data(rd_data), .rd_hit(rd_hit), .tx(tx)
    );

    always #5 clk = ~clk;

    function automatic logic line_at(int tt);
        for (int i = 0; i < starts.size(); i++)
            if (tt >= starts[i] && tt < starts[i] + FRAME) begin
                int k = (tt - starts[i]) / CPB;
                logic [7:0] b = bytes[i];
                if (k == 0) return 1'b0;
                if (k <= 8) return b[k-1];
                if (NBITS == 11 && k == 9) return ^b;
                return 1'b1;
            end
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_at(int tt);
        int c = 0;
        logic b = 1'b0;
        for (int i = 0; i < starts.size(); i++) begin
            if (starts[i] > tt) c++;
            if (tt >= starts[i] && tt < starts[i] + FRAME) b = 1'b1;
        end
        return {19'd0, 5'(c), 4'd0, ovf, c == DEPTH, c == 0, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0d got %h expected %h", tag, t, got, exp);
        end
    endtask

    // Apply the effect of a bus cycle at edge e: a byte starts when the line frees up.
    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w);
        int e = t + 1, occ = 0, popping = 0;
        if (!rst_n || !w) return;
        if (a == BASE) begin
            foreach (starts[i]) begin
                if (starts[i] >= e) occ++;
                if (starts[i] == e) popping = 1;
            end
            if (occ - popping < DEPTH) begin
                int s = (e + 1 > last_end) ? e + 1 : last_end;
                starts.push_back(s);
                bytes.push_back(d[7:0]);
                last_end = s + FRAME;
            end else ovf = 1'b1;
        end else if (a == STAT && d[3]) ovf = 1'b0;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
        iobus_addr = a;
        iobus_out = d;
        iobus_wr = w;
        model_edge(a, d, w);
        @(posedge clk);
        t++;
        @(negedge clk);
        while (starts.size() > 0 && starts[0] + FRAME <= t) begin
            void'(starts.pop_front());
            void'(bytes.pop_front());
        end
        chk("tx", 32'(tx), 32'(line_at(t)));
        chk("rd_hit", 32'(rd_hit), 32'(a == STAT));
        chk("rd_data", rd_data, a == STAT ? status_at(t) : 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(STAT, 32'd0, 1'b0);
    endtask

    initial begin
        idle(2);
        chk("reset_status", rd_data, 32'h0000_0002);
        @(negedge clk) rst_n = 1'b1;
        idle(2);
        step(BASE, 32'h0000_0055, 1'b1);
        idle(45);
        step(BASE, 32'h0000_00A5, 1'b1);
        step(BASE, 32'h0000_003C, 1'b1);
        idle(85);
        for (int i = 0; i < 6; i++) step(BASE, 32'(8'h10 + i), 1'b1);
        idle(1);
        chk("overflow_status", rd_data, 32'h0000_040D);
        step(STAT, 32'h0000_0008, 1'b1);
        chk("ovf_clear_status", rd_data, 32'h0000_0405);
        step(BASE, 32'd0, 1'b0);
        idle(210);
        step(BASE, 32'h0000_00A5, 1'b1);
        idle(17);
        chk("bit3_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", 32'(tx), 32'd1);
        starts.delete();
        bytes.delete();
        ovf = 1'b0;
        last_end = 0;
        idle(2);
        @(negedge clk) rst_n = 1'b1;
        idle(1);
        chk("post_reset_status", rd_data, 32'h0000_0002);
        step(BASE, 32'h0000_0007, 1'b1);
        idle(48);
        step(BASE, 32'h0000_0003, 1'b1);
        idle(48);
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 35) step(BASE, $urandom, 1'b1);
            else if (r < 40) step(STAT, $urandom, 1'b1);
            else if (r < 45) step(BASE + 32'd8, $urandom, 1'b1);
            else if (r < 55) step(BASE, $urandom, 1'b0);
            else idle(1);
        end
        idle(5 * FRAME);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
